// File: rtl/pwm_cap_pkg.sv
// Shared types and default sizing for the PWM capture block.
// The PWM_CAP_DEGLITCH_EN macro enables the input deglitch filter.
package pwm_cap_pkg;

   localparam int DEF_SYS_FREQ_HZ = 50_000_000;
   localparam int DEF_PWM_FREQ    = 50_000;
   localparam int DEF_PWM_COUNTER = DEF_SYS_FREQ_HZ / DEF_PWM_FREQ;
   localparam int DEF_TIMEOUT     = 2 * DEF_PWM_COUNTER + 2;

   typedef enum logic [1:0] {
      SYNC_WAIT,
      MEAS_HIGH,
      MEAS_LOW
   } state_e;

   function automatic int count_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the raw PWM input and derives level, rise and fall.
// PWM_CAP_DEGLITCH_EN adds a stable-run filter ahead of the edge detector.
module pwm_edge_sync
`ifdef PWM_CAP_DEGLITCH_EN
#(
   parameter int DEGLITCH_LEN = 4
)
`endif
(
   input  logic clk,
   input  logic resetn,
   input  logic pwm_in,
   output logic pwm_s,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic pwm_d_q, pwm_d_d;
   logic level;

`ifdef PWM_CAP_DEGLITCH_EN
   localparam int RW = $clog2(DEGLITCH_LEN + 1);

   logic          filt_q, filt_d;
   logic [RW-1:0] run_q, run_d;

   // level flips only once the new value has been seen DEGLITCH_LEN times in a row
   always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (sync2_q != filt_q) begin
         if (run_q == RW'(DEGLITCH_LEN - 1)) begin
            filt_d = sync2_q;
         end else begin
            run_d = run_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         filt_q <= 1'b0;
         run_q  <= '0;
      end else begin
         filt_q <= filt_d;
         run_q  <= run_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   always_comb begin
      sync1_d = pwm_in;
      sync2_d = sync1_q;
      pwm_d_d = level;
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         pwm_d_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         pwm_d_q <= pwm_d_d;
      end
   end

   assign pwm_s = level;
   assign rise  = level & ~pwm_d_q;
   assign fall  = ~level & pwm_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in clk cycles, with stuck detect.
// Define PWM_CAP_DEGLITCH_EN to filter input pulses shorter than DEGLITCH_LEN.
module pwm_capture
   import pwm_cap_pkg::*;
#(
   parameter int SYS_FREQ_HZ = DEF_SYS_FREQ_HZ,
   parameter int PWM_FREQ    = DEF_PWM_FREQ,
   parameter int PWM_COUNTER = SYS_FREQ_HZ / PWM_FREQ,
   parameter int TIMEOUT     = 2 * PWM_COUNTER + 2,
   parameter int COUNT_WIDTH = count_width(TIMEOUT)
`ifdef PWM_CAP_DEGLITCH_EN
   ,
   parameter int DEGLITCH_LEN = 4
`endif
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   pwm_in,
   output logic [COUNT_WIDTH-1:0] high_count,
   output logic [COUNT_WIDTH-1:0] period_count,
   output logic                   sample_valid,
   output logic                   stuck,
   output logic                   stuck_level
);

   localparam logic [COUNT_WIDTH-1:0] TMO = COUNT_WIDTH'(TIMEOUT);

   logic pwm_s, rise, fall;

   pwm_edge_sync
`ifdef PWM_CAP_DEGLITCH_EN
   #(.DEGLITCH_LEN(DEGLITCH_LEN))
`endif
   u_sync (
      .clk    (clk),
      .resetn (resetn),
      .pwm_in (pwm_in),
      .pwm_s  (pwm_s),
      .rise   (rise),
      .fall   (fall)
   );

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNT_WIDTH-1:0] high_pend_q, high_pend_d;
   logic [COUNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic [COUNT_WIDTH-1:0] period_q, period_d;
   logic                   valid_q, valid_d;
   logic                   stuck_q, stuck_d;
   logic                   stuck_lvl_q, stuck_lvl_d;
   logic                   tmo_done_q, tmo_done_d;
   logic                   timeout;

   // tmo_done keeps the saturated counter from firing again until a rise
   assign timeout = (cnt_q == TMO) & ~tmo_done_q & ~rise;

   always_comb begin
      state_d     = state_q;
      high_pend_d = high_pend_q;
      high_cnt_d  = high_cnt_q;
      period_d    = period_q;
      valid_d     = 1'b0;
      stuck_d     = stuck_q;
      stuck_lvl_d = stuck_lvl_q;

      if (rise) begin
         cnt_d = COUNT_WIDTH'(1);
      end else if (cnt_q == TMO) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + COUNT_WIDTH'(1);
      end

      if (rise) begin
         tmo_done_d = 1'b0;
      end else if (timeout) begin
         tmo_done_d = 1'b1;
      end else begin
         tmo_done_d = tmo_done_q;
      end

      if (timeout) begin
         state_d     = SYNC_WAIT;
         stuck_d     = 1'b1;
         stuck_lvl_d = pwm_s;
         period_d    = TMO;
         high_cnt_d  = pwm_s ? TMO : '0;
         valid_d     = 1'b1;
      end else begin
         unique case (state_q)
            SYNC_WAIT: begin
               if (rise) state_d = MEAS_HIGH;
            end
            MEAS_HIGH: begin
               if (fall) begin
                  high_pend_d = cnt_q;
                  state_d     = MEAS_LOW;
               end
            end
            MEAS_LOW: begin
               if (rise) begin
                  high_cnt_d = high_pend_q;
                  period_d   = cnt_q;
                  valid_d    = 1'b1;
                  stuck_d    = 1'b0;
                  state_d    = MEAS_HIGH;
               end
            end
            default: state_d = SYNC_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q     <= SYNC_WAIT;
         cnt_q       <= '0;
         high_pend_q <= '0;
         high_cnt_q  <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
         stuck_lvl_q <= 1'b0;
         tmo_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         high_pend_q <= high_pend_d;
         high_cnt_q  <= high_cnt_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         stuck_q     <= stuck_d;
         stuck_lvl_q <= stuck_lvl_d;
         tmo_done_q  <= tmo_done_d;
      end
   end

   assign high_count   = high_cnt_q;
   assign period_count = period_q;
   assign sample_valid = valid_q;
   assign stuck        = stuck_q;
   assign stuck_level  = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture against a timestamp-based period model.
// Build with PWM_CAP_DEGLITCH_EN to model the filtered input as well.
module tb_pwm_capture;
   import pwm_cap_pkg::*;

   localparam int T  = DEF_TIMEOUT;
   localparam int PC = DEF_PWM_COUNTER;
   localparam int CW = count_width(T);
`ifdef PWM_CAP_DEGLITCH_EN
   localparam int DL = 4;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic          pwm_in = 1'b0;
   logic [CW-1:0] high_count;
   logic [CW-1:0] period_count;
   logic          sample_valid;
   logic          stuck;
   logic          stuck_level;

   pwm_capture dut (
      .clk          (clk),
      .resetn       (resetn),
      .pwm_in       (pwm_in),
      .high_count   (high_count),
      .period_count (period_count),
      .sample_valid (sample_valid),
      .stuck        (stuck),
      .stuck_level  (stuck_level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // input samples per posedge since reset release, index 1 = first edge
   bit xs[65536];
   bit fs[65536];
   int k;
   int last_rise, fall_c, eh, ep, c;
   bit synced, have_fall, fired, e_stuck, e_lvl;
   bit ev, lvl, prv, rs, fl, all_diff;

   function automatic bit xv(input int i);
      return (i < 1) ? 1'b0 : xs[i];
   endfunction

   function automatic bit fv(input int i);
      return (i < 1) ? 1'b0 : fs[i];
   endfunction

   // synchronized level seen by the measurement logic in cycle cc
   function automatic bit lv(input int cc);
`ifdef PWM_CAP_DEGLITCH_EN
      return fv(cc - 2);
`else
      return xv(cc - 1);
`endif
   endfunction

   always @(posedge clk) begin
      if (resetn) begin
         k = 0;
         last_rise = 0;
         fall_c = 0;
         synced = 0;
         have_fall = 0;
         fired = 0;
         e_stuck = 0;
         e_lvl = 0;
         #1;
         check("rst_high", high_count, 0);
         check("rst_period", period_count, 0);
         check("rst_valid", sample_valid, 0);
         check("rst_stuck", stuck, 0);
         check("rst_level", stuck_level, 0);
      end else if (k < 65535) begin
         k++;
         xs[k] = pwm_in;
`ifdef PWM_CAP_DEGLITCH_EN
         all_diff = 1;
         for (int i = 0; i < DL; i++)
            if (xv(k - i) == fv(k - 1)) all_diff = 0;
         fs[k] = all_diff ? xs[k] : fv(k - 1);
`endif
         c = k - 1;
         lvl = lv(c);
         prv = lv(c - 1);
         rs = lvl & ~prv;
         fl = ~lvl & prv;
         ev = 0;
         if (rs) begin
            if (synced && have_fall) begin
               ev = 1;
               eh = fall_c - last_rise;
               ep = c - last_rise;
               e_stuck = 0;
            end
            synced = 1;
            have_fall = 0;
            fired = 0;
            last_rise = c;
         end else begin
            if (fl && synced) begin
               fall_c = c;
               have_fall = 1;
            end
            if (c - last_rise >= T && !fired) begin
               ev = 1;
               ep = T;
               eh = lvl ? T : 0;
               e_stuck = 1;
               e_lvl = lvl;
               fired = 1;
               synced = 0;
               have_fall = 0;
            end
         end
         #1;
         check("valid", sample_valid, ev);
         if (ev) begin
            check("high", high_count, eh);
            check("period", period_count, ep);
         end
         check("stuck", stuck, e_stuck);
         check("stuck_level", stuck_level, e_lvl);
      end else begin
         check("history_budget", k, 0);
      end
   end

   int gp = 0;

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      resetn = 1'b0;
   endtask

   task automatic hold(input bit v, input int n);
      pwm_in = v;
      repeat (n) @(negedge clk);
   endtask

   // DAC-style generator: counts 0..PC, high while count < v
   task automatic gen(input int v, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         pwm_in = (gp < v) && !(glitch && (gp == 100 || gp == 101));
         gp = (gp == PC) ? 0 : gp + 1;
         @(negedge clk);
      end
   endtask

   int hi, lo;

   initial begin
      do_reset();
      hold(1'b0, 2500);

      gp = 0;
      gen(250, 6 * (PC + 1), 1'b0);
      gen(250, 300, 1'b0);
      gen(600, 5 * (PC + 1), 1'b0);

      repeat (6) gen($urandom_range(1, PC), 2 * (PC + 1), 1'b0);

      repeat (10) begin
         hi = $urandom_range(1, 1200);
         lo = $urandom_range(1, 1200);
         hold(1'b1, hi);
         hold(1'b0, lo);
      end

      gp = 0;
      gen(400, 2 * (PC + 1), 1'b0);
      hold(1'b1, 2500);

      gp = 0;
      gen(250, 3 * (PC + 1) + 600, 1'b0);
      do_reset();
      gen(250, 4 * (PC + 1), 1'b0);

      gen(250, 4 * (PC + 1), 1'b1);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
